argmax_classifier: RTL
======================

Name: argmax_classifier

Overview:
- Final stage of the zyNet inference pipeline, directly downstream of the last fully-connected layer.
- Takes the layer's parallel output vector (one word per neuron, 10 neurons for MNIST) and scans it serially to find the index of the largest value.
- Publishes that index as the classification result, read by the AXI-lite register at offset 8.
- Raises the completion interrupt that software and the bench wait on.

Parameters:
- DATA_WIDTH, 16, width of one neuron output word (matches `dataWidth).
- NUM_INPUT, 10, number of neuron outputs in the vector; legal range 2..64.
- IDX_WIDTH, 32, width of the published class index (sized for a 32-bit AXI read).

Ports:
- s_axi_aclk  in  1  system clock; all logic on rising edge.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- i_data  in  NUM_INPUT*DATA_WIDTH  neuron outputs; element n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
- i_valid  in  1  i_data is valid this cycle.
- i_ready  out  1  block can accept a vector.
- o_class  out  IDX_WIDTH  index of the maximum element; held until the next result.
- o_max  out  DATA_WIDTH  value of the maximum element; held until the next result.
- o_valid  out  1  one-cycle pulse when o_class/o_max update.
- intr  out  1  completion interrupt; one-cycle pulse coincident with o_valid.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low: s_axi_aresetn low immediately forces state to IDLE.
- Reset values: i_ready=0 while in reset, 1 after the first clock edge in IDLE. o_class=0, o_max=0, o_valid=0, intr=0. Internal buffer and counter cleared.
- States:
  - IDLE: i_ready=1.
    - On i_valid&&i_ready: capture i_data into an internal buffer, max<=elem0, idx<=0, cnt<=1, go to SCAN.
  - SCAN: i_ready=0.
    - Each cycle compare buf[cnt] with max. If strictly greater: max<=buf[cnt], idx<=cnt.
    - cnt<=cnt+1.
    - When cnt==NUM_INPUT-1 has been compared, go to DONE.
  - DONE (one cycle): o_class<=idx zero-extended to IDX_WIDTH, o_max<=max, o_valid=1, intr=1, i_ready=0. Next state IDLE.
- Latency: the handshake is at edge T; o_valid is high in the cycle after edge T+NUM_INPUT-1, i.e. NUM_INPUT cycles after acceptance. Example: NUM_INPUT=10 gives o_valid 10 cycles after the accept edge.
- Throughput: one vector per NUM_INPUT+1 cycles. The earliest next accept is the cycle after DONE.
- Comparison:
  - Unsigned by default.
  - Ties keep the lowest index (strict > only).
  - No arithmetic overflow is possible; only comparison is performed.
- i_valid while i_ready=0: ignored, no capture, no error. Upstream holds data until the handshake.
- i_data changes after acceptance: no effect; the buffer was captured at the handshake.
- o_class/o_max stability: they change only in DONE and are stable otherwise, including through later IDLE/SCAN periods.
- Reset mid-SCAN: scan aborts, no o_valid/intr pulse, outputs return to 0, and after reset release the block accepts a fresh vector.
- Parameter check: NUM_INPUT<2 is illegal; the simulation flags it with $error at elaboration.

Optional Feature:
- ARGMAX_SIGNED_EN defined: elements and o_max are treated as two's-complement signed DATA_WIDTH values, so 16'hFFFF (-1) < 16'h0001.
- ARGMAX_SIGNED_EN undefined: unsigned comparison, so 16'hFFFF is the largest value.
- Tie rule, latency and all other behaviour are identical in both builds.

Test Plan (DATA_WIDTH=16, NUM_INPUT=10):
- Basic: vector {0x0010,0x0020,0x0500,0x0030,0,0,0,0,0,0x0100}, i_valid one cycle. Expect: o_class=2, o_max=0x0500, o_valid and intr single pulse exactly 10 cycles after accept.
- Tie: elements 3 and 7 both 0x7000, rest 0x0001. Expect: o_class=3, o_max=0x7000.
- Max at the ends: max at element 0 gives o_class=0; then a new vector with max at element 9 gives o_class=9. Back-to-back accept is allowed the cycle after DONE; expect exactly two o_valid pulses 11 cycles apart.
- Busy: hold i_valid high with a changed vector during SCAN. Expect i_ready=0, first result unaffected, second vector accepted in the first IDLE cycle.
- Reset mid-SCAN: assert s_axi_aresetn low at cycle 4 of SCAN. Expect outputs 0 immediately, no intr pulse. After release, the vector {all 0, element 5=0x0042} gives o_class=5.
- Signedness: vector with element 1=0xFFFF, element 4=0x0002, rest 0.
  - ARGMAX_SIGNED_EN undefined: o_class=1, o_max=0xFFFF.
  - ARGMAX_SIGNED_EN defined: o_class=4, o_max=0x0002.

Source files
------------

// File: rtl/argmax_classifier.sv
// ============================================================================
// Module   : argmax_classifier
// Purpose  : Serial argmax over a captured neuron-output vector; publishes the
//            winning index/value with a one-cycle valid + interrupt pulse.
//            Define ARGMAX_SIGNED_EN for two's-complement comparison.
// Revision : 1.0
// ============================================================================
`default_nettype none

module argmax_classifier #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUT  = 10,
  parameter int IDX_WIDTH  = 32
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [NUM_INPUT*DATA_WIDTH-1:0] i_data,
  input  logic                            i_valid,
  output logic                            i_ready,
  output logic [IDX_WIDTH-1:0]            o_class,
  output logic [DATA_WIDTH-1:0]           o_max,
  output logic                            o_valid,
  output logic                            intr
);

  localparam int CNT_W = (NUM_INPUT > 2) ? $clog2(NUM_INPUT) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(NUM_INPUT - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_scan = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  generate
    if (NUM_INPUT < 2) begin : g_bad_num_input
      $error("argmax_classifier: NUM_INPUT must be at least 2");
    end
  endgenerate

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic                  r_armed;
  logic [DATA_WIDTH-1:0] r_buf [NUM_INPUT];
  logic [DATA_WIDTH-1:0] r_max;
  logic [CNT_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_class;
  logic [DATA_WIDTH-1:0] r_omax;

  logic [DATA_WIDTH-1:0] w_elem;
  logic                  w_gt;
  logic [DATA_WIDTH-1:0] w_new_max;
  logic [CNT_W-1:0]      w_new_idx;
  logic                  w_accept;

  assign w_elem = r_buf[r_cnt];

`ifdef ARGMAX_SIGNED_EN
  assign w_gt = $signed(w_elem) > $signed(r_max);
`else
  assign w_gt = w_elem > r_max;
`endif

  // Strict compare keeps the lowest index on ties.
  assign w_new_max = w_gt ? w_elem : r_max;
  assign w_new_idx = w_gt ? r_cnt  : r_idx;
  assign w_accept  = i_valid && i_ready;

  // State register; r_armed holds i_ready low until the first edge after reset.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state <= c_st_idle;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_state_next = c_st_scan;
      c_st_scan: if (r_cnt == c_last) w_state_next = c_st_done;
      c_st_done: w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    i_ready = (r_state == c_st_idle) && r_armed;
    o_valid = (r_state == c_st_done);
    intr    = (r_state == c_st_done);
  end

  // Results are loaded on the edge entering DONE so they are valid with o_valid.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < NUM_INPUT; i++) r_buf[i] <= '0;
      r_max   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_class <= '0;
      r_omax  <= '0;
    end else if (r_state == c_st_idle && w_accept) begin
      for (int i = 0; i < NUM_INPUT; i++) r_buf[i] <= i_data[i*DATA_WIDTH +: DATA_WIDTH];
      r_max <= i_data[DATA_WIDTH-1:0];
      r_idx <= '0;
      r_cnt <= CNT_W'(1);
    end else if (r_state == c_st_scan) begin
      r_max <= w_new_max;
      r_idx <= w_new_idx;
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == c_last) begin
        r_class <= w_new_idx;
        r_omax  <= w_new_max;
      end
    end
  end

  assign o_class = IDX_WIDTH'(r_class);
  assign o_max   = r_omax;

endmodule

`default_nettype wire
